// File: rtl/ad_serial_responder.sv
// ---------------------------------------------------------------------------
// ad_serial_responder
//
// Emulates the converter end of a 10-bit, 4-bit-address serial ADC link.
// It samples the master's chip select, I/O clock and address line. It shifts
// out the previous conversion result MSB-first and captures the channel
// address. It then runs a fixed-length conversion, with EOC held low while the
// conversion runs.
//
// Parameters
//   CONV_CYCLES    conversion time in CLK cycles. It must stay below the
//                  master's end-of-conversion wait.
//
// Ports
//   CLK            system clock
//   RSTn           synchronous active-low reset
//   AD_CSn         chip select from the master (async to CLK, active low)
//   AD_Clk         I/O clock from the master (async to CLK)
//   AD_Address     serial address, MSB first, sampled on I/O clock rise
//   Ch_Value       stand-in analog value for the selected channel
//   Ch_Sel         address captured by the last complete transaction
//   AD_DigData_Out serial data to the master
//   AD_DigData_En  output enable for AD_DigData_Out (follows synced CSn)
//   EOC            end of conversion, low while converting
//   Result         current conversion result register
// ---------------------------------------------------------------------------
module ad_serial_responder #(
    parameter int CONV_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       AD_CSn,
    input  logic       AD_Clk,
    input  logic       AD_Address,
    input  logic [9:0] Ch_Value,
    output logic [3:0] Ch_Sel,
    output logic       AD_DigData_Out,
    output logic       AD_DigData_En,
    output logic       EOC,
    output logic [9:0] Result
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;

    localparam int            CW        = $clog2(CONV_CYCLES + 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

    // Fixed reference values returned for the special addresses.
    localparam logic [9:0] REF_HALF = 10'h200;
    localparam logic [9:0] REF_FULL = 10'h3FF;

    // Synchronizers. Bit 0 is the metastability flop and bit 1 is the
    // usable synchronized level. Bit 2, present on CSn and the I/O clock
    // only, is the previous level used for edge detection.
    logic [2:0]    cs_sync_q,   cs_sync_d;
    logic [2:0]    clk_sync_q,  clk_sync_d;
    logic [1:0]    addr_sync_q, addr_sync_d;

    logic [1:0]    state_q,     state_d;
    logic [3:0]    bit_cnt_q,   bit_cnt_d;
    logic [3:0]    addr_sr_q,   addr_sr_d;
    logic [CW-1:0] conv_cnt_q,  conv_cnt_d;
    logic [3:0]    ch_sel_q,    ch_sel_d;
    logic          dout_q,      dout_d;
    logic          en_q,        en_d;
    logic          eoc_q,       eoc_d;
    logic [9:0]    result_q,    result_d;

    logic          cs_fall, cs_rise;
    logic          sclk_rise, sclk_fall;
    logic          addr_bit;
    logic [3:0]    bit_cnt_inc;
    logic [3:0]    bit_idx;

    // Maps the captured channel to the value that a conversion produces.
    function automatic logic [9:0] conv_value(input logic [3:0] sel,
                                              input logic [9:0] chv);
        logic [9:0] v;
        case (sel)
            4'hB:    v = REF_HALF;
            4'hC:    v = 10'h000;
            4'hD:    v = REF_FULL;
            4'hE,
            4'hF:    v = 10'h000;
            default: v = chv;      // 0x0..0xA are real channels
        endcase
        return v;
    endfunction

    always_comb begin
        cs_sync_d   = {cs_sync_q[1:0],  AD_CSn};
        clk_sync_d  = {clk_sync_q[1:0], AD_Clk};
        addr_sync_d = {addr_sync_q[0],  AD_Address};
    end

    assign cs_fall   = ~cs_sync_q[1] &  cs_sync_q[2];
    assign cs_rise   =  cs_sync_q[1] & ~cs_sync_q[2];
    assign sclk_rise =  clk_sync_q[1] & ~clk_sync_q[2];
    assign sclk_fall = ~clk_sync_q[1] &  clk_sync_q[2];
    // Address passes through two flops, the same depth as the I/O clock.
    // The sample taken on a detected rising edge is therefore the level
    // that was present at the pin edge.
    assign addr_bit  = addr_sync_q[1];

    assign bit_cnt_inc = bit_cnt_q + 4'd1;
    assign bit_idx     = 4'd9 - bit_cnt_inc;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_sr_d  = addr_sr_q;
        conv_cnt_d = conv_cnt_q;
        ch_sel_d   = ch_sel_q;
        dout_d     = dout_q;
        eoc_d      = eoc_q;
        result_d   = result_q;
        // The output enable follows synchronized CSn in every state. This
        // also covers "enable on start" and "disable on abort".
        en_d       = ~cs_sync_q[1];

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    dout_d    = result_q[9];
                    bit_cnt_d = 4'd0;
                    addr_sr_d = 4'd0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cs_rise) begin
                    // Early CSn release: drop the transaction and keep the
                    // previous result and channel.
                    state_d = ST_IDLE;
                end else begin
                    if (sclk_rise && (bit_cnt_q < 4'd4))
                        addr_sr_d = {addr_sr_q[2:0], addr_bit};
                    if (sclk_fall) begin
                        bit_cnt_d = bit_cnt_inc;
                        if (bit_cnt_inc < 4'd10) begin
                            // Data changes only on falling edges, so it
                            // is stable at the master's rising-edge sample.
                            dout_d = result_q[bit_idx];
                        end else begin
                            dout_d     = 1'b0;
                            ch_sel_d   = addr_sr_q;
                            conv_cnt_d = '0;
                            eoc_d      = 1'b0;
                            state_d    = ST_CONVERT;
                        end
                    end
                end
            end

            ST_CONVERT: begin
                // I/O clocks and CSn edges are ignored here. A CSn fall
                // during conversion does not start a transaction later.
                if (conv_cnt_q == CONV_LAST) begin
                    result_d = conv_value(ch_sel_q, Ch_Value);
                    eoc_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    conv_cnt_d = conv_cnt_q + CW'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cs_sync_q   <= 3'b111;
            clk_sync_q  <= 3'b000;
            addr_sync_q <= 2'b00;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            addr_sr_q   <= 4'd0;
            conv_cnt_q  <= '0;
            ch_sel_q    <= 4'd0;
            dout_q      <= 1'b0;
            en_q        <= 1'b0;
            eoc_q       <= 1'b1;
            result_q    <= 10'd0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            clk_sync_q  <= clk_sync_d;
            addr_sync_q <= addr_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_sr_q   <= addr_sr_d;
            conv_cnt_q  <= conv_cnt_d;
            ch_sel_q    <= ch_sel_d;
            dout_q      <= dout_d;
            en_q        <= en_d;
            eoc_q       <= eoc_d;
            result_q    <= result_d;
        end
    end

    assign Ch_Sel         = ch_sel_q;
    assign AD_DigData_Out = dout_q;
    assign AD_DigData_En  = en_q;
    assign EOC            = eoc_q;
    assign Result         = result_q;

endmodule

// File: tb/tb_ad_serial_responder.sv
// ---------------------------------------------------------------------------
// tb_ad_serial_responder
//
// Drives serial transactions into the responder and compares the outputs with
// a behavioural model. The model holds the result register value and the
// selected channel, and it computes conversion values directly from the
// address map. Inputs are driven on the falling edge of CLK, and outputs are
// also sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ad_serial_responder;

    localparam int CONV = 1000;
    localparam int HP   = 13;

    logic       CLK;
    logic       RSTn;
    logic       AD_CSn;
    logic       AD_Clk;
    logic       AD_Address;
    logic [9:0] Ch_Value;
    logic [3:0] Ch_Sel;
    logic       AD_DigData_Out;
    logic       AD_DigData_En;
    logic       EOC;
    logic [9:0] Result;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state.
    logic [9:0] mres;
    logic [3:0] msel;

    // Length of the most recent completed EOC-low pulse, in CLK cycles.
    int low_cnt  = 0;
    int last_low = 0;

    ad_serial_responder #(.CONV_CYCLES(CONV)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .AD_CSn         (AD_CSn),
        .AD_Clk         (AD_Clk),
        .AD_Address     (AD_Address),
        .Ch_Value       (Ch_Value),
        .Ch_Sel         (Ch_Sel),
        .AD_DigData_Out (AD_DigData_Out),
        .AD_DigData_En  (AD_DigData_En),
        .EOC            (EOC),
        .Result         (Result)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!EOC) begin
            low_cnt <= low_cnt + 1;
        end else begin
            if (low_cnt != 0) last_low <= low_cnt;
            low_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ref_conv(input logic [3:0] a, input logic [9:0] v);
        if (a <= 4'd10)  return v;
        if (a == 4'hB)   return 10'h200;
        if (a == 4'hD)   return 10'h3FF;
        return 10'h000;
    endfunction

    // Master-side transaction: CSn low, then nclk I/O clocks with half-period
    // hp. Data is captured when the I/O clock rises, and CSn is then released.
    task automatic txn(input logic [3:0] a, input int nclk, input int hp,
                       output logic [9:0] got);
        got    = '0;
        AD_CSn = 1'b0;
        repeat (20) @(negedge CLK);
        for (int i = 0; i < nclk; i++) begin
            AD_Address = (i < 4) ? a[3-i] : 1'($urandom_range(1));
            repeat (hp) @(negedge CLK);
            got    = {got[8:0], AD_DigData_Out};
            AD_Clk = 1'b1;
            repeat (hp) @(negedge CLK);
            AD_Clk = 1'b0;
        end
        repeat (hp) @(negedge CLK);
        AD_CSn = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic wait_conv(input logic [9:0] exp_res);
        int n;
        n = 0;
        while (EOC !== 1'b1 && n < 1200) begin
            @(negedge CLK);
            n++;
        end
        chk("eoc_rise_timeout", 32'(n < 1200), 32'd1);
        @(negedge CLK);
        chk("eoc_low_len", last_low, CONV);
        chk("result", Result, exp_res);
    endtask

    // One complete transaction followed by its conversion.
    task automatic do_full(input logic [3:0] a, input logic [9:0] v);
        logic [9:0] got;
        Ch_Value = v;
        txn(a, 10, HP, got);
        chk("data_out", got, mres);
        chk("ch_sel", Ch_Sel, a);
        chk("eoc_low", EOC, 1'b0);
        msel = a;
        mres = ref_conv(a, v);
        wait_conv(mres);
    endtask

    initial begin
        logic [9:0] got;
        logic [3:0] a;
        logic [9:0] v;

        // Apply reset while driving random pin levels.
        RSTn       = 1'b0;
        AD_CSn     = 1'($urandom_range(1));
        AD_Clk     = 1'($urandom_range(1));
        AD_Address = 1'($urandom_range(1));
        Ch_Value   = 10'($urandom);
        repeat (5) @(negedge CLK);
        chk("rst_eoc", EOC, 1'b1);
        chk("rst_en", AD_DigData_En, 1'b0);
        chk("rst_result", Result, 10'd0);
        chk("rst_ch_sel", Ch_Sel, 4'd0);
        chk("rst_dout", AD_DigData_Out, 1'b0);
        AD_CSn = 1'b1; AD_Clk = 1'b0; AD_Address = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        mres = 10'd0;
        msel = 4'd0;

        // Preload Result, then run the basic transaction.
        do_full(4'h0, 10'h2A5);
        do_full(4'h5, 10'h155);
        do_full(4'($urandom_range(10)), 10'($urandom));

        // Fixed reference addresses. Each result is read back by the next
        // transaction.
        do_full(4'hB, 10'($urandom));
        do_full(4'hC, 10'($urandom));
        do_full(4'hD, 10'($urandom));

        // Random transactions.
        for (int k = 0; k < 5; k++) do_full(4'($urandom), 10'($urandom));

        // Abort after 6 I/O clocks.
        Ch_Value = 10'($urandom);
        txn(~msel, 6, HP, got);
        chk("abort_en", AD_DigData_En, 1'b0);
        chk("abort_eoc", EOC, 1'b1);
        chk("abort_result", Result, mres);
        chk("abort_ch_sel", Ch_Sel, msel);
        do_full(4'($urandom_range(10)), 10'($urandom));

        // Run a complete transaction while a conversion is in progress.
        a = 4'($urandom_range(10));
        v = 10'($urandom);
        Ch_Value = v;
        txn(a, 10, HP, got);
        chk("data_out", got, mres);
        msel = a;
        mres = ref_conv(a, v);
        txn(4'hF, 10, 6, got);
        chk("conv_dout_zero", got, 10'd0);
        chk("conv_eoc_still_low", EOC, 1'b0);
        chk("conv_ch_sel", Ch_Sel, a);
        wait_conv(mres);
        do_full(4'hE, 10'($urandom));

        // Reset at roughly conversion count 500.
        a = 4'($urandom_range(10));
        Ch_Value = 10'($urandom);
        txn(a, 10, HP, got);
        chk("data_out", got, mres);
        repeat (483) @(negedge CLK);
        chk("pre_rst_eoc", EOC, 1'b0);
        RSTn = 1'b0;
        @(negedge CLK);
        chk("midrst_eoc", EOC, 1'b1);
        chk("midrst_result", Result, 10'd0);
        chk("midrst_ch_sel", Ch_Sel, 4'd0);
        RSTn = 1'b1;
        mres = 10'd0;
        msel = 4'd0;
        repeat (3) @(negedge CLK);
        do_full(4'h7, 10'($urandom));
        do_full(4'h3, 10'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ad_serial_responder.md
# ad_serial_responder

Synthesizable responder for the 10-bit, 4-bit-address serial ADC protocol. It emulates the converter end of the link: it samples CS, I/O clock and the address line from the ADC master, shifts out the previous conversion result MSB-first, runs a timed conversion and signals end-of-conversion. It provides the target for loop-back tests of the ADC master on the board and in simulation, and it can stand in for the converter when the chip is absent.

## Interface
- CONV_CYCLES, 1000: conversion time in CLK cycles, i.e. 20 us at 50 MHz. This must stay below the master's 1050-cycle wait.
- CLK  input  1  system clock, 50 MHz.
- RSTn  input  1  reset. Synchronous, active-low.
- AD_CSn  input  1  chip select from the master. Asynchronous to CLK; active low.
- AD_Clk  input  1  I/O clock from the master. Asynchronous to CLK.
- AD_Address  input  1  serial address from the master, MSB first. Sampled on I/O clock rising edges.
- Ch_Value  input  10  analog-channel stand-in value for the channel on Ch_Sel. Sampled at the end of conversion.
- Ch_Sel  output  4  address captured in the last complete transaction.
- AD_DigData_Out  output  1  serial data to the master.
- AD_DigData_En  output  1  output enable for AD_DigData_Out. The top level builds the tri-state from this.
- EOC  output  1  end of conversion. Low while converting.
- Result  output  10  current conversion result register. Debug/LED use.

## Operation
- Input conditioning:
  - 2-flop synchronizer on AD_CSn, AD_Clk and AD_Address.
  - A third flop on CSn and Clk provides edge detection.
  - All edges referred to below are the detected, synchronized edges.
- Reset values: Ch_Sel=0, AD_DigData_Out=0, AD_DigData_En=0, EOC=1, Result=10'd0, state IDLE, bit counter 0, conversion counter 0.
- State machine: IDLE, SHIFT, CONVERT.
- IDLE:
  - Waits for a CSn falling edge.
  - On the edge: AD_DigData_Out <= Result[9], AD_DigData_En <= 1, bit counter <= 0, address shift register <= 0, go to SHIFT.
- SHIFT, I/O clock rising edge: while bit counter < 4, shift the AD_Address sample into the address register (MSB first).
- SHIFT, I/O clock falling edge:
  - bit counter += 1.
  - If the new count is < 10, AD_DigData_Out <= Result[9 - count].
  - At count 10: AD_DigData_Out <= 0, Ch_Sel <= address register, conversion counter <= 0, EOC <= 0, go to CONVERT.
- SHIFT, CSn rising edge before 10 falling edges:
  - Abort: AD_DigData_En <= 0, go to IDLE.
  - Result, Ch_Sel and EOC are unchanged, and no conversion runs.
- CONVERT:
  - The conversion counter increments every CLK.
  - When it reaches CONV_CYCLES-1, Result is loaded and EOC <= 1, then go to IDLE.
  - Result load by Ch_Sel:
    - 0-10 (0x0-0xA) -> Ch_Value.
    - 0xB -> 10'h200 (half reference).
    - 0xC -> 10'h000.
    - 0xD -> 10'h3FF.
    - 0xE and 0xF -> 10'h000.
- AD_DigData_En tracks the synchronized CSn in every state: 1 while low, 0 while high.
- Extra I/O clocks in CONVERT, or after count 10, are ignored. AD_DigData_Out stays 0.
- CSn falling in CONVERT is ignored. A transaction starts only on a CSn falling edge seen in IDLE, and CSn must return high before the next transaction is recognized.
- RSTn low in any state: on the next CLK every register returns to its reset value, including mid-shift and mid-conversion.

## Timing
- Synchronizer latency: pin edge to detected edge is 2-3 CLK.
- Edge to outputs: registered outputs update 1 CLK after detection, so 3-4 CLK after the pin edge.
- I/O clock requirement:
  - Each half-period must be at least 6 CLK.
  - The master's 13-CLK half-period (520 ns period) gives data settling of at least 9 CLK before the master's next rising-edge sample.
- Data/address edges:
  - Data changes only after falling edges, so it is stable across the rising-edge sample point.
  - Address bits must be stable at least 4 CLK around each rising edge.
- CS setup: the first bit (Result[9]) is valid 4 CLK after CSn falls, well inside the master's 72-CLK CS setup.
- Conversion:
  - EOC falls 1 CLK after the 10th detected falling edge.
  - EOC rises exactly CONV_CYCLES CLK later.
  - Result updates in the same cycle that EOC rises.

## Test plan
- Reset state: hold RSTn low 5 CLK with random pins. Then EOC=1, AD_DigData_En=0, Result=0, Ch_Sel=0.
- Basic transaction:
  - Stimulus: Result preloaded to 10'h2A5 by a prior conversion; master transaction at 13-CLK half-period with address 4'b0101 and Ch_Value=10'h155.
  - Required: the master captures 10'h2A5; Ch_Sel=5; EOC low for exactly 1000 CLK; then Result=10'h155 and a second transaction returns 10'h155.
- Fixed references: addresses 0xB, 0xC and 0xD give Result 10'h200, 10'h000 and 10'h3FF on the following transaction.
- Abort: CSn rises after 6 I/O clocks. Required: EOC stays 1, Result and Ch_Sel unchanged, AD_DigData_En drops within 4 CLK.
- CS during conversion: CSn low with 10 clocks while EOC=0. Required: no new conversion, EOC rises on schedule, AD_DigData_Out=0.
- Reset mid-conversion: RSTn low for 1 CLK at conversion count 500. Required: EOC=1 and Result=0 next CLK; a normal transaction afterwards works.
